// File: rtl/triangle_intersect_nearest.sv
// Streaming ray/triangle intersector: 5-stage Moller-Trumbore pipeline feeding a
// per-ray nearest-hit accumulator with a valid/ready result port.
module triangle_intersect_nearest #(
    parameter int TOTAL_PREC = 27,
    parameter int FRAC_BITS  = 22,
    parameter int ID_BITS    = 8,
    parameter int CNT_BITS   = 8,
    parameter int CULL_MODE  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0][TOTAL_PREC-1:0]   a,
    input  logic [2:0][TOTAL_PREC-1:0]   b,
    input  logic [2:0][TOTAL_PREC-1:0]   c,
    input  logic [2:0][TOTAL_PREC-1:0]   n,
    input  logic [2:0][TOTAL_PREC-1:0]   orig,
    input  logic [2:0][TOTAL_PREC-1:0]   dir,
    input  logic [ID_BITS-1:0]           in_id,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_hit,
    output logic signed [TOTAL_PREC-1:0] out_t,
    output logic signed [TOTAL_PREC-1:0] out_det,
    output logic [ID_BITS-1:0]           out_id,
    output logic [CNT_BITS-1:0]          out_count
);
    localparam int W = TOTAL_PREC;
    typedef logic signed [W-1:0] fx_t;
    typedef logic [2:0][W-1:0]   vec_t;
    localparam fx_t ZERO = '0;

    function automatic fx_t fmul(input fx_t x, input fx_t y);
        return fx_t'(((2*W)'(x) * (2*W)'(y)) >>> FRAC_BITS);
    endfunction

    function automatic fx_t vdot(input vec_t x, input vec_t y);
        return fmul(fx_t'(x[0]), fx_t'(y[0])) + fmul(fx_t'(x[1]), fx_t'(y[1]))
             + fmul(fx_t'(x[2]), fx_t'(y[2]));
    endfunction

    function automatic vec_t vcross(input vec_t x, input vec_t y);
        vec_t r;
        r[0] = fmul(fx_t'(x[1]), fx_t'(y[2])) - fmul(fx_t'(x[2]), fx_t'(y[1]));
        r[1] = fmul(fx_t'(x[2]), fx_t'(y[0])) - fmul(fx_t'(x[0]), fx_t'(y[2]));
        r[2] = fmul(fx_t'(x[0]), fx_t'(y[1])) - fmul(fx_t'(x[1]), fx_t'(y[0]));
        return r;
    endfunction

    function automatic vec_t vsub(input vec_t x, input vec_t y);
        vec_t r;
        for (int i = 0; i < 3; i++) r[i] = x[i] - y[i];
        return r;
    endfunction

    logic en;
    logic s1_vld, s2_vld, s3_vld, s4_vld, s5_vld;
    logic s1_last, s2_last, s3_last, s4_last, s5_last;
    logic [ID_BITS-1:0] s1_id, s2_id, s3_id, s4_id, s5_id;
    vec_t s1_a, s1_b, s1_c, s1_orig, s1_dir;
    fx_t  s1_nd;
    vec_t s2_e1, s2_e2, s2_s, s2_dir;
    logic s2_cull, s3_cull, s4_cull;
    vec_t s3_h, s3_se1, s3_e1, s3_e2, s3_s, s3_dir;
    fx_t  s4_det, s4_t, s4_u, s4_v;
    logic s5_hit;
    fx_t  s5_t, s5_det;

    logic               acc_any;
    fx_t                acc_t, acc_det;
    logic [ID_BITS-1:0] acc_id;
    logic [CNT_BITS-1:0] acc_cnt;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // Facing the ray direction flips the winding so det stays positive for either side.
    logic nd_pos, cull_c, hit_c;
    vec_t pe1, pe2;
    assign nd_pos = s1_nd > ZERO;
    assign pe1    = nd_pos ? s1_b : s1_a;
    assign pe2    = nd_pos ? s1_a : s1_b;
    assign cull_c = (CULL_MODE == 1) && nd_pos;

    assign hit_c = !s4_cull && (s4_det > ZERO) && (s4_u >= ZERO) && (s4_u <= s4_det)
                && (s4_v >= ZERO) && (s4_v <= fx_t'(s4_det - s4_u)) && (s4_t > ZERO);

    // Nearest compare on t/det by cross-multiplication; strict '<' keeps the earlier hit on ties.
    logic signed [2*W-1:0] p_new, p_best;
    logic                  take, m_any;
    fx_t                   m_t, m_det;
    logic [ID_BITS-1:0]    m_id;
    logic [CNT_BITS-1:0]   m_cnt;
    assign p_new  = (2*W)'(s5_t) * (2*W)'(acc_det);
    assign p_best = (2*W)'(acc_t) * (2*W)'(s5_det);
    assign take   = s5_hit && (!acc_any || p_new < p_best);
    assign m_any  = acc_any || s5_hit;
    assign m_t    = take ? s5_t   : acc_t;
    assign m_det  = take ? s5_det : acc_det;
    assign m_id   = take ? s5_id  : acc_id;
    assign m_cnt  = (&acc_cnt) ? acc_cnt : acc_cnt + CNT_BITS'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s1_vld, s2_vld, s3_vld, s4_vld, s5_vld} <= '0;
            {s1_last, s2_last, s3_last, s4_last, s5_last} <= '0;
            {s1_id, s2_id, s3_id, s4_id, s5_id} <= '0;
            {s1_a, s1_b, s1_c, s1_orig, s1_dir} <= '0;
            s1_nd <= '0;
            {s2_e1, s2_e2, s2_s, s2_dir} <= '0;
            {s2_cull, s3_cull, s4_cull} <= '0;
            {s3_h, s3_se1, s3_e1, s3_e2, s3_s, s3_dir} <= '0;
            {s4_det, s4_t, s4_u, s4_v} <= '0;
            {s5_hit, s5_t, s5_det} <= '0;
            {acc_any, acc_t, acc_det, acc_id, acc_cnt} <= '0;
            {out_valid, out_hit, out_t, out_det, out_id, out_count} <= '0;
        end else if (en) begin
            s1_vld  <= in_valid;
            s1_last <= in_last;
            s1_id   <= in_id;
            s1_a    <= a;
            s1_b    <= b;
            s1_c    <= c;
            s1_orig <= orig;
            s1_dir  <= dir;
            s1_nd   <= vdot(n, dir);

            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            s2_id   <= s1_id;
            s2_e1   <= vsub(pe1, s1_c);
            s2_e2   <= vsub(pe2, s1_c);
            s2_s    <= vsub(s1_orig, s1_c);
            s2_dir  <= s1_dir;
            s2_cull <= cull_c;

            s3_vld  <= s2_vld;
            s3_last <= s2_last;
            s3_id   <= s2_id;
            s3_h    <= vcross(s2_dir, s2_e2);
            s3_se1  <= vcross(s2_s, s2_e1);
            s3_e1   <= s2_e1;
            s3_e2   <= s2_e2;
            s3_s    <= s2_s;
            s3_dir  <= s2_dir;
            s3_cull <= s2_cull;

            s4_vld  <= s3_vld;
            s4_last <= s3_last;
            s4_id   <= s3_id;
            s4_det  <= vdot(s3_e1, s3_h);
            s4_t    <= vdot(s3_e2, s3_se1);
            s4_u    <= vdot(s3_h, s3_s);
            s4_v    <= vdot(s3_dir, s3_se1);
            s4_cull <= s3_cull;

            s5_vld  <= s4_vld;
            s5_last <= s4_last;
            s5_id   <= s4_id;
            s5_hit  <= hit_c;
            s5_t    <= s4_t;
            s5_det  <= s4_det;

            out_valid <= s5_vld && s5_last;
            if (s5_vld) begin
                if (s5_last) begin
                    out_hit   <= m_any;
                    out_t     <= m_t;
                    out_det   <= m_det;
                    out_id    <= m_id;
                    out_count <= m_cnt;
                    {acc_any, acc_t, acc_det, acc_id, acc_cnt} <= '0;
                end else begin
                    acc_any <= m_any;
                    acc_t   <= m_t;
                    acc_det <= m_det;
                    acc_id  <= m_id;
                    acc_cnt <= m_cnt;
                end
            end
        end
    end
endmodule

// File: tb/tb_triangle_intersect_nearest.sv
// Bench for triangle_intersect_nearest: directed scenarios plus random rays checked
// against an integer reference model, on a double-sided and a culling instance.
module tb_triangle_intersect_nearest;
    localparam int W = 27;
    localparam int F = 22;
    localparam longint ONE  = 4194304;
    localparam longint HALF = 2097152;
    typedef logic [2:0][W-1:0] vec_t;
    typedef struct {
        bit     hit;
        longint t;
        longint det;
        longint id;
        longint cnt;
    } res_t;

    logic clk = 0;
    logic rst, in_valid, in_last, out_ready;
    vec_t a, b, c, n, orig, dir;
    logic [7:0] in_id;
    logic in_ready0, out_valid0, out_hit0, in_ready1, out_valid1, out_hit1;
    logic signed [W-1:0] out_t0, out_det0, out_t1, out_det1;
    logic [7:0] out_id0, out_count0, out_id1, out_count1;

    int vectors = 0;
    int miscompares = 0;
    int rx = 0;
    bit rand_mode = 0;
    res_t exp0[$], exp1[$];
    vec_t qa[$], qb[$], qc[$], qn[$], qo[$], qd[$];
    int   qid[$];
    res_t r0, r1;

    always #5 clk = ~clk;

    triangle_intersect_nearest #(.CULL_MODE(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .c(c), .n(n), .orig(orig), .dir(dir),
        .in_id(in_id), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
        .out_hit(out_hit0), .out_t(out_t0), .out_det(out_det0), .out_id(out_id0),
        .out_count(out_count0));

    triangle_intersect_nearest #(.CULL_MODE(1)) dut_cull (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .c(c), .n(n), .orig(orig), .dir(dir),
        .in_id(in_id), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
        .out_hit(out_hit1), .out_t(out_t1), .out_det(out_det1), .out_id(out_id1),
        .out_count(out_count1));

    task automatic chk(input string tag, input longint got, input longint expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // ---- reference model: plain integer arithmetic on Q(27,22) values ----
    function automatic longint wrapw(input longint x);
        longint m;
        m = x & 64'sh7FFFFFF;
        if (m >= 64'sd67108864) m -= 64'sd134217728;
        return m;
    endfunction

    function automatic longint fm(input longint x, input longint y);
        return wrapw((x * y) >>> F);
    endfunction

    function automatic longint comp(input vec_t v, input int i);
        logic signed [W-1:0] e;
        e = v[i];
        return longint'(e);
    endfunction

    function automatic vec_t mk(input longint x, input longint y, input longint z);
        vec_t v;
        v[0] = W'(x);
        v[1] = W'(y);
        v[2] = W'(z);
        return v;
    endfunction

    function automatic void tri_model(input vec_t ta, tb, tc, tn, to, td, input bit cull_en,
                                      output bit hit, output longint t, output longint det);
        longint d[3], p1[3], p2[3], e1[3], e2[3], s[3], h[3], q[3];
        longint nd, u, v;
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            d[i] = comp(td, i);
            nd = wrapw(nd + fm(comp(tn, i), d[i]));
        end
        for (int i = 0; i < 3; i++) begin
            p1[i] = (nd > 0) ? comp(tb, i) : comp(ta, i);
            p2[i] = (nd > 0) ? comp(ta, i) : comp(tb, i);
            e1[i] = wrapw(p1[i] - comp(tc, i));
            e2[i] = wrapw(p2[i] - comp(tc, i));
            s[i]  = wrapw(comp(to, i) - comp(tc, i));
        end
        h[0] = wrapw(fm(d[1], e2[2]) - fm(d[2], e2[1]));
        h[1] = wrapw(fm(d[2], e2[0]) - fm(d[0], e2[2]));
        h[2] = wrapw(fm(d[0], e2[1]) - fm(d[1], e2[0]));
        q[0] = wrapw(fm(s[1], e1[2]) - fm(s[2], e1[1]));
        q[1] = wrapw(fm(s[2], e1[0]) - fm(s[0], e1[2]));
        q[2] = wrapw(fm(s[0], e1[1]) - fm(s[1], e1[0]));
        det = wrapw(fm(e1[0], h[0]) + fm(e1[1], h[1]) + fm(e1[2], h[2]));
        t   = wrapw(fm(e2[0], q[0]) + fm(e2[1], q[1]) + fm(e2[2], q[2]));
        u   = wrapw(fm(h[0], s[0]) + fm(h[1], s[1]) + fm(h[2], s[2]));
        v   = wrapw(fm(d[0], q[0]) + fm(d[1], q[1]) + fm(d[2], q[2]));
        hit = !(cull_en && nd > 0) && det > 0 && u >= 0 && u <= det && v >= 0
              && v <= wrapw(det - u) && t > 0;
    endfunction

    function automatic res_t ray_model(input bit cull_en);
        res_t r;
        bit h;
        longint t, d;
        r.hit = 0; r.t = 0; r.det = 0; r.id = 0; r.cnt = 0;
        for (int k = 0; k < qa.size(); k++) begin
            tri_model(qa[k], qb[k], qc[k], qn[k], qo[k], qd[k], cull_en, h, t, d);
            if (h && (!r.hit || t * r.det < r.t * d)) begin
                r.hit = 1; r.t = t; r.det = d; r.id = qid[k];
            end
            if (r.cnt < 255) r.cnt++;
        end
        return r;
    endfunction

    task automatic clear_ray();
        qa.delete(); qb.delete(); qc.delete(); qn.delete(); qo.delete(); qd.delete(); qid.delete();
    endtask

    // ---- driver ----
    task automatic send_beat(input vec_t ta, tb, tc, tn, to, td, input int id, input bit last);
        bit acc = 0;
        int waitc = 0;
        a = ta; b = tb; c = tc; n = tn; orig = to; dir = td;
        in_id = 8'(id); in_last = last; in_valid = 1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
            if (!acc) begin
                waitc++;
                if (rand_mode) out_ready = 1'($urandom_range(0, 1));
                if (waitc > 200) begin
                    $display("FAIL send_timeout: got stalled expected accepted");
                    $fatal(1);
                end
            end
        end
        qa.push_back(ta); qb.push_back(tb); qc.push_back(tc);
        qn.push_back(tn); qo.push_back(to); qd.push_back(td); qid.push_back(id);
        if (last) begin
            exp0.push_back(ray_model(0));
            exp1.push_back(ray_model(1));
            clear_ray();
        end
        in_valid = 0;
    endtask

    task automatic send_std(input longint z, input longint ox, input longint nz,
                            input int id, input bit last);
        send_beat(mk(-HALF, -HALF, z), mk(HALF, -HALF, z), mk(0, HALF, z), mk(0, 0, nz),
                  mk(ox, 0, 2 * ONE), mk(0, 0, -ONE), id, last);
    endtask

    task automatic wait_out(input string tag);
        int k = 0;
        while (!out_valid0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_arrived"}, out_valid0, 1);
    endtask

    function automatic longint rnd(input int r);
        return longint'($urandom_range(0, 2 * r)) - longint'(r);
    endfunction

    // ---- scoreboard on accepted results ----
    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready) begin
            if (exp0.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                r0 = exp0.pop_front();
                r1 = exp1.pop_front();
                chk("sb_hit", out_hit0, r0.hit);
                chk("sb_t", out_t0, r0.t);
                chk("sb_det", out_det0, r0.det);
                chk("sb_id", out_id0, r0.id);
                chk("sb_count", out_count0, r0.cnt);
                chk("sb_cull_valid", out_valid1, 1);
                chk("sb_cull_ready", in_ready1, 1);
                chk("sb_cull_hit", out_hit1, r1.hit);
                chk("sb_cull_t", out_t1, r1.t);
                chk("sb_cull_id", out_id1, r1.id);
                chk("sb_cull_count", out_count1, r1.cnt);
                rx++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int e, rx0, nb;
        rst = 1; in_valid = 0; in_last = 0; in_id = 0; out_ready = 1;
        a = '0; b = '0; c = '0; n = '0; orig = '0; dir = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid0, 0);
        chk("rst_hit", out_hit0, 0);
        chk("rst_t", out_t0, 0);
        chk("rst_count", out_count0, 0);
        chk("rst_in_ready", in_ready0, 1);
        rst = 0;
        @(posedge clk);
        #1;

        // single triangle with latency
        send_std(0, 0, ONE, 3, 1);
        e = 1;
        while (!out_valid0 && e < 20) begin
            @(posedge clk);
            #1;
            e++;
        end
        chk("latency", e, 6);
        chk("st_hit", out_hit0, 1);
        chk("st_det", out_det0, 4194304);
        chk("st_t", out_t0, 8388608);
        chk("st_id", out_id0, 3);
        chk("st_count", out_count0, 1);
        chk("st_cull_hit", out_hit1, 1);
        @(posedge clk); #1;

        // two triangles, both orders
        send_std(0, 0, ONE, 3, 0);
        send_std(ONE, 0, ONE, 7, 1);
        wait_out("two");
        chk("two_id", out_id0, 7);
        chk("two_t", out_t0, 4194304);
        chk("two_det", out_det0, 4194304);
        chk("two_count", out_count0, 2);
        @(posedge clk); #1;
        send_std(ONE, 0, ONE, 7, 0);
        send_std(0, 0, ONE, 3, 1);
        wait_out("rev");
        chk("rev_id", out_id0, 7);
        chk("rev_t", out_t0, 4194304);
        @(posedge clk); #1;

        // back face with original winding: misses in both modes
        send_std(0, 0, -ONE, 3, 1);
        wait_out("bf");
        chk("bf_hit", out_hit0, 0);
        chk("bf_det", out_det0, 0);
        chk("bf_cull_hit", out_hit1, 0);
        @(posedge clk); #1;

        // back face with reversed winding: hits double-sided, culled otherwise
        send_beat(mk(HALF, -HALF, 0), mk(-HALF, -HALF, 0), mk(0, HALF, 0), mk(0, 0, -ONE),
                  mk(0, 0, 2 * ONE), mk(0, 0, -ONE), 5, 1);
        wait_out("rw");
        chk("rw_hit", out_hit0, 1);
        chk("rw_t", out_t0, 8388608);
        chk("rw_cull_hit", out_hit1, 0);
        @(posedge clk); #1;

        // miss
        send_std(0, ONE, ONE, 3, 1);
        wait_out("miss");
        chk("miss_hit", out_hit0, 0);
        chk("miss_t", out_t0, 0);
        chk("miss_id", out_id0, 0);
        @(posedge clk); #1;

        // backpressure: two back-to-back single-beat rays
        rx0 = rx;
        out_ready = 0;
        send_std(0, 0, ONE, 3, 1);
        send_std(ONE, 0, ONE, 7, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid0) begin
                chk("bp_in_ready", in_ready0, 0);
                chk("bp_hold_id", out_id0, 3);
                chk("bp_hold_t", out_t0, 8388608);
            end
        end
        chk("bp_valid_held", out_valid0, 1);
        out_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_delivered", rx - rx0, 2);

        // reset in the middle of a 3-beat ray
        send_std(0, 0, ONE, 1, 0);
        send_std(ONE, 0, ONE, 2, 0);
        rst = 1;
        #1;
        chk("mr_valid", out_valid0, 0);
        chk("mr_t", out_t0, 0);
        chk("mr_det", out_det0, 0);
        chk("mr_id", out_id0, 0);
        chk("mr_count", out_count0, 0);
        clear_ray();
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        send_std(0, 0, ONE, 4, 0);
        send_std(ONE, 0, ONE, 6, 1);
        wait_out("mr_next");
        chk("mr_next_count", out_count0, 2);
        chk("mr_next_id", out_id0, 6);
        @(posedge clk); #1;

        // counter saturation
        for (int k = 0; k < 260; k++)
            send_beat(mk(rnd(4194304), rnd(4194304), 0), mk(rnd(4194304), rnd(4194304), 0),
                      mk(rnd(4194304), rnd(4194304), 0), mk(0, 0, ONE),
                      mk(rnd(1048576), rnd(1048576), 2 * ONE), mk(0, 0, -ONE), k & 255, k == 259);
        wait_out("sat");
        chk("sat_count", out_count0, 255);
        @(posedge clk); #1;

        // random rays with random output backpressure
        rand_mode = 1;
        for (int r = 0; r < 60; r++) begin
            nb = $urandom_range(1, 6);
            for (int k = 0; k < nb; k++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                send_beat(mk(rnd(4194304), rnd(4194304), rnd(1048576)),
                          mk(rnd(4194304), rnd(4194304), rnd(1048576)),
                          mk(rnd(4194304), rnd(4194304), rnd(1048576)),
                          mk(rnd(1048576), rnd(1048576), ($urandom_range(0, 1) != 0) ? ONE : -ONE),
                          mk(rnd(2097152), rnd(2097152), 4194304 + longint'($urandom_range(0, 4194304))),
                          mk(rnd(1048576), rnd(1048576), -ONE),
                          $urandom_range(0, 255), k == nb - 1);
            end
        end
        rand_mode = 0;
        out_ready = 1;
        repeat (30) @(posedge clk);
        #1;
        chk("all_delivered", exp0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/triangle_intersect_nearest.md
Name: triangle_intersect_nearest

Overview:
- Streaming, handshaked successor to the single-triangle intersector.
- Accepts a sequence of triangles per ray, one per cycle, tagged with an ID and a `last` flag.
- Each triangle runs through a fixed 5-stage Möller–Trumbore pipeline with a programmable ray origin, optional back-face culling and degenerate-triangle rejection.
- Keeps the nearest hit per ray and emits one result per ray on a valid/ready output; sits between the scene triangle fetcher and the shading stage.

Parameters:
- TOTAL_PREC, 27, signed fixed-point word width.
- FRAC_BITS, 22, fractional bits (1.0 = 2^FRAC_BITS).
- ID_BITS, 8, triangle ID width.
- CNT_BITS, 8, per-ray triangle counter width.
- CULL_MODE, 0, 0 = double-sided; 1 = cull triangles with n·dir > 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  triangle beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- a, b, c  in  3 x TOTAL_PREC signed each  vertices
- n  in  3 x TOTAL_PREC signed  face normal
- orig  in  3 x TOTAL_PREC signed  ray origin
- dir  in  3 x TOTAL_PREC signed  ray direction
- in_id  in  ID_BITS  triangle ID
- in_last  in  1  final triangle of current ray
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_hit  out  1  any triangle hit
- out_t  out  TOTAL_PREC signed  unnormalised t of nearest hit (distance = t/det)
- out_det  out  TOTAL_PREC signed  det of nearest hit
- out_id  out  ID_BITS  ID of nearest hit
- out_count  out  CNT_BITS  triangles tested for this ray (saturating)

Behaviour:
- Reset (async): all stage valids 0; accumulator cleared; out_valid 0; out_hit 0; out_t, out_det, out_id, out_count all 0. A partially accumulated ray is discarded.
- Global enable en = !(out_valid && !out_ready); in_ready = en. When en = 0, every pipeline and accumulator register holds.
- Fixed multiply: full 2*TOTAL_PREC signed product, arithmetic shift right FRAC_BITS, truncate to TOTAL_PREC. Dot and cross sums wrap modulo 2^TOTAL_PREC.

Pipeline (all registers load only when en = 1):
- E0 (accept edge), S1: register vertices, orig, dir, id, last; nd = n·dir.
- E1, S2:
  - pe1/pe2 = (nd > 0) ? (b, a) : (a, b).
  - e1 = pe1 - c; e2 = pe2 - c; s = orig - c.
  - cull = (CULL_MODE == 1 && nd > 0).
- E2, S3: h = dir × e2; se1 = s × e1.
- E3, S4: det = e1·h; t = e2·se1; u = h·s; v = dir·se1.
- E4, S5: hit = !cull && det > 0 && u >= 0 && u <= det && v >= 0 && v <= det - u && t > 0.
- E5, accumulator update on S5 valid:
  - Candidate replaces best if hit && (!any || t*best_det < best_t*det), using full-width products. Ties keep the earlier triangle.
  - count increments, saturating at 2^CNT_BITS - 1.
- If S5.last: result registers load the merged value (including this triangle), out_valid is set, and the accumulator clears in the same edge.
- Latency: out_valid is high after E5, i.e. 6 cycles after acceptance of the last beat with no stall.
- On a miss ray: out_hit = 0 and out_t, out_det, out_id = 0.
- Throughput: one beat per cycle. Back-to-back rays need no bubble; a new ray's first beat may follow a last beat immediately.
- Output handshake: out_valid falls on the out_ready edge unless a new last reaches E5 in the same edge, in which case the new result loads and out_valid stays 1. Result outputs stay stable while out_valid && !out_ready.

Test Plan:
- Single triangle (FRAC_BITS 22):
  - Stimulus: a = (-0.5, -0.5, 0), b = (0.5, -0.5, 0), c = (0, 0.5, 0), n = (0, 0, 1), orig = (0, 0, 2), dir = (0, 0, -1), id = 3, last = 1.
  - Required: out_valid 6 cycles later; hit = 1; det = 4194304; t = 8388608; id = 3; count = 1. Internal u = v = 1048576.
- Two-triangle ray:
  - Stimulus: the triangle above (id 3), then the same triangle at z = 1 (id 7, last).
  - Required: hit = 1; id = 7; t = 4194304; det = 4194304; count = 2. Reversed order gives the same result.
- Back-face handling: n = (0, 0, -1), otherwise as in the first scenario.
  - CULL_MODE = 1: hit = 0.
  - CULL_MODE = 0: swapped winding gives det = -4194304, so hit = 0.
- Miss:
  - Stimulus: orig = (1.0, 0, 2), otherwise as in the first scenario.
  - Required: u = -3145728; hit = 0; t, id = 0.
- Backpressure:
  - Stimulus: two 1-beat rays back-to-back with out_ready = 0 for 10 cycles.
  - Required: in_ready drops while out_valid is high; the first result is held stable; both results are delivered in order after out_ready rises, with no loss or duplication.
- Reset mid-ray:
  - Stimulus: assert rst after 2 beats of a 3-beat ray.
  - Required: all outputs 0 immediately. The next full ray reports only its own triangles (count correct).
